// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller
// -------------------
// Multi-cycle control unit for an RV32I core. A state machine sequences each
// instruction through FETCH, DECODE and one to three execution states, and
// drives every datapath enable and mux select from the current state and the
// instruction fields.
//
// Parameters
//   TRAP_ON_ILLEGAL : 1 = an illegal encoding parks the core in TRAP until reset,
//                     0 = an illegal encoding is dropped and the FSM refetches.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   opcode, f3, f7  : IR[6:0], IR[14:12], IR[31:25]
//   zero, sign      : ALU result == 0, ALU result bit 31
//   pc_w, oldpc_w   : PC / OldPC write enables
//   IR_w            : instruction register write enable
//   adr_src         : memory address select (0 PC, 1 result)
//   memwrite        : data memory write
//   regwrite        : register file write
//   imm_src         : immediate format (I 000, S 001, B 010, J 011, U 100)
//   ALUcontrol      : add 000, sub 001, and 010, or 011, xor 100, slt 101
//   Alu_srcA        : 0 PC, 1 OldPC, 2 A
//   Alu_srcB        : 0 B, 1 imm, 2 constant 4
//   result_src      : 0 ALU_reg, 1 MDR, 2 ALU_out, 3 imm
//   halted          : high while in TRAP
//   state           : current state code, for debug
module riscv_mc_controller #(
    parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       sign,
    output logic       pc_w,
    output logic       oldpc_w,
    output logic       IR_w,
    output logic       adr_src,
    output logic       memwrite,
    output logic       regwrite,
    output logic [2:0] imm_src,
    output logic [2:0] ALUcontrol,
    output logic [1:0] Alu_srcA,
    output logic [1:0] Alu_srcB,
    output logic [1:0] result_src,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StAluWb    = 4'd4,
        StMemAdr   = 4'd5,
        StMemRead  = 4'd6,
        StMemWb    = 4'd7,
        StMemWrite = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalrPc   = 4'd11,
        StLui      = 4'd12,
        StTrap     = 4'd13
    } state_e;

    // Opcodes
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // Immediate formats
    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    // ALU operations
    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    // Mux selects
    localparam logic [1:0] SrcAPc    = 2'd0;
    localparam logic [1:0] SrcAOldPc = 2'd1;
    localparam logic [1:0] SrcAReg   = 2'd2;
    localparam logic [1:0] SrcBReg   = 2'd0;
    localparam logic [1:0] SrcBImm   = 2'd1;
    localparam logic [1:0] SrcBFour  = 2'd2;
    localparam logic [1:0] ResAluReg = 2'd0;
    localparam logic [1:0] ResMdr    = 2'd1;
    localparam logic [1:0] ResAluOut = 2'd2;
    localparam logic [1:0] ResImm    = 2'd3;

    // Where an illegal encoding sends the FSM.
    localparam state_e IllState = (TRAP_ON_ILLEGAL != 0) ? StTrap : StFetch;

    state_e state_q, state_d;

    // Decode helpers; each is only consumed in the state that owns that decode point.
    state_e     dec_next;
    logic [2:0] r_alu;
    logic       r_ok;
    logic [2:0] i_alu;
    logic       i_ok;
    logic       br_take;
    logic       br_ok;
    state_e     mem_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        dec_next = IllState;
        case (opcode)
            OpR:              dec_next = StExecR;
            OpImm:            dec_next = StExecI;
            OpLoad, OpStore:  dec_next = StMemAdr;
            OpBranch:         dec_next = StBranch;
            OpJal:            dec_next = StJal;
            OpJalr:           dec_next = (f3 == 3'b000) ? StExecI : IllState;
            OpLui:            dec_next = StLui;
            default:          dec_next = IllState;
        endcase

        // R-type: f7 must be zero for every op except sub.
        r_alu = AluAdd;
        r_ok  = 1'b0;
        case (f3)
            3'b000: begin
                if (f7 == F7Alt) begin
                    r_alu = AluSub;
                    r_ok  = 1'b1;
                end else if (f7 == F7Base) begin
                    r_alu = AluAdd;
                    r_ok  = 1'b1;
                end
            end
            3'b111: begin
                r_alu = AluAnd;
                r_ok  = (f7 == F7Base);
            end
            3'b110: begin
                r_alu = AluOr;
                r_ok  = (f7 == F7Base);
            end
            3'b100: begin
                r_alu = AluXor;
                r_ok  = (f7 == F7Base);
            end
            3'b010: begin
                r_alu = AluSlt;
                r_ok  = (f7 == F7Base);
            end
            default: begin
                r_alu = AluAdd;
                r_ok  = 1'b0;
            end
        endcase
        // Bad encodings drive the default op rather than a half-decoded one.
        if (!r_ok) begin
            r_alu = AluAdd;
        end

        i_alu = AluAdd;
        i_ok  = 1'b1;
        case (f3)
            3'b000:  i_alu = AluAdd;
            3'b111:  i_alu = AluAnd;
            3'b110:  i_alu = AluOr;
            3'b100:  i_alu = AluXor;
            3'b010:  i_alu = AluSlt;
            default: i_ok  = 1'b0;
        endcase

        br_take = 1'b0;
        br_ok   = 1'b1;
        case (f3)
            3'b000:  br_take = zero;
            3'b001:  br_take = ~zero;
            3'b100:  br_take = sign;
            3'b101:  br_take = ~sign;
            default: br_ok   = 1'b0;
        endcase

        mem_next = IllState;
        if (f3 == 3'b010) begin
            if (opcode == OpLoad) begin
                mem_next = StMemRead;
            end else if (opcode == OpStore) begin
                mem_next = StMemWrite;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        oldpc_w    = 1'b0;
        IR_w       = 1'b0;
        adr_src    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        imm_src    = ImmI;
        ALUcontrol = AluAdd;
        Alu_srcA   = SrcAPc;
        Alu_srcB   = SrcBReg;
        result_src = ResAluReg;
        halted     = 1'b0;

        case (state_q)
            StFetch: begin
                adr_src    = 1'b0;
                IR_w       = 1'b1;
                oldpc_w    = 1'b1;
                Alu_srcA   = SrcAPc;
                Alu_srcB   = SrcBFour;
                result_src = ResAluOut;
                pc_w       = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                // Precompute the branch/jal target into ALU_reg.
                Alu_srcA = SrcAOldPc;
                Alu_srcB = SrcBImm;
                if (opcode == OpBranch) begin
                    imm_src = ImmB;
                end else if (opcode == OpJal) begin
                    imm_src = ImmJ;
                end
                state_d = dec_next;
            end
            StExecR: begin
                Alu_srcA   = SrcAReg;
                Alu_srcB   = SrcBReg;
                ALUcontrol = r_alu;
                state_d    = r_ok ? StAluWb : IllState;
            end
            StExecI: begin
                Alu_srcA = SrcAReg;
                Alu_srcB = SrcBImm;
                imm_src  = ImmI;
                if (opcode == OpJalr) begin
                    ALUcontrol = AluAdd;
                    state_d    = StJalrPc;
                end else begin
                    ALUcontrol = i_ok ? i_alu : AluAdd;
                    state_d    = i_ok ? StAluWb : IllState;
                end
            end
            StAluWb: begin
                result_src = ResAluReg;
                regwrite   = 1'b1;
                state_d    = StFetch;
            end
            StMemAdr: begin
                Alu_srcA = SrcAReg;
                Alu_srcB = SrcBImm;
                imm_src  = (opcode == OpStore) ? ImmS : ImmI;
                state_d  = mem_next;
            end
            StMemRead: begin
                adr_src    = 1'b1;
                result_src = ResAluReg;
                state_d    = StMemWb;
            end
            StMemWb: begin
                result_src = ResMdr;
                regwrite   = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src    = 1'b1;
                result_src = ResAluReg;
                memwrite   = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                // ALU compares rs1-rs2 while ALU_reg still holds the target.
                Alu_srcA   = SrcAReg;
                Alu_srcB   = SrcBReg;
                ALUcontrol = AluSub;
                result_src = ResAluReg;
                pc_w       = br_ok & br_take;
                state_d    = br_ok ? StFetch : IllState;
            end
            StJal, StJalrPc: begin
                // PC takes the target from ALU_reg; ALU forms OldPC+4 as the link value.
                pc_w       = 1'b1;
                result_src = ResAluReg;
                Alu_srcA   = SrcAOldPc;
                Alu_srcB   = SrcBFour;
                ALUcontrol = AluAdd;
                state_d    = StAluWb;
            end
            StLui: begin
                imm_src    = ImmU;
                result_src = ResImm;
                regwrite   = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                halted  = 1'b1;
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset holds state at FETCH; block its writes until release.
        if (!rst) begin
            pc_w     = 1'b0;
            oldpc_w  = 1'b0;
            IR_w     = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller. Two instances share all inputs:
// dut traps on illegal encodings, dut0 refetches. Each cycle the stimulus
// pushes the hand-written expected output vector of both; the monitor pops
// one entry per falling edge and compares.
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       sign;

    logic       pc_w, oldpc_w, IR_w, adr_src, memwrite, regwrite, halted;
    logic [2:0] imm_src, ALUcontrol;
    logic [1:0] Alu_srcA, Alu_srcB, result_src;
    logic [3:0] state;

    logic       pc_w0, oldpc_w0, IR_w0, adr_src0, memwrite0, regwrite0, halted0;
    logic [2:0] imm_src0, ALUcontrol0;
    logic [1:0] Alu_srcA0, Alu_srcB0, result_src0;
    logic [3:0] state0;

    riscv_mc_controller #(.TRAP_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .f7(f7), .zero(zero), .sign(sign),
        .pc_w(pc_w), .oldpc_w(oldpc_w), .IR_w(IR_w), .adr_src(adr_src),
        .memwrite(memwrite), .regwrite(regwrite), .imm_src(imm_src),
        .ALUcontrol(ALUcontrol), .Alu_srcA(Alu_srcA), .Alu_srcB(Alu_srcB),
        .result_src(result_src), .halted(halted), .state(state)
    );

    riscv_mc_controller #(.TRAP_ON_ILLEGAL(0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .f7(f7), .zero(zero), .sign(sign),
        .pc_w(pc_w0), .oldpc_w(oldpc_w0), .IR_w(IR_w0), .adr_src(adr_src0),
        .memwrite(memwrite0), .regwrite(regwrite0), .imm_src(imm_src0),
        .ALUcontrol(ALUcontrol0), .Alu_srcA(Alu_srcA0), .Alu_srcB(Alu_srcB0),
        .result_src(result_src0), .halted(halted0), .state(state0)
    );

    always #5 clk = ~clk;

    // {state, pc_w, oldpc_w, IR_w, adr_src, memwrite, regwrite, imm_src, ALUcontrol,
    //  Alu_srcA, Alu_srcB, result_src, halted}
    logic [22:0] act1, act0;
    assign act1 = {state, pc_w, oldpc_w, IR_w, adr_src, memwrite, regwrite, imm_src,
                   ALUcontrol, Alu_srcA, Alu_srcB, result_src, halted};
    assign act0 = {state0, pc_w0, oldpc_w0, IR_w0, adr_src0, memwrite0, regwrite0, imm_src0,
                   ALUcontrol0, Alu_srcA0, Alu_srcB0, result_src0, halted0};

    function automatic logic [22:0] ev(input logic [3:0] st, input logic pcw, input logic opw,
                                       input logic irw, input logic adr, input logic mw,
                                       input logic rw, input logic [2:0] imm,
                                       input logic [2:0] alu, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic h);
        return {st, pcw, opw, irw, adr, mw, rw, imm, alu, sa, sb, rs, h};
    endfunction

    typedef struct {
        string       name;
        logic [22:0] e1;
        logic [22:0] e0;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;

    // Expected per-state vectors (hand-derived).
    logic [22:0] v_rst, v_f, v_d_i, v_d_b, v_d_j, v_xr_sub, v_xr_ill, v_xi_xor, v_xi_add;
    logic [22:0] v_wb, v_ma_l, v_ma_s, v_mr, v_mwb, v_mw, v_br1, v_br0, v_jal, v_jalr;
    logic [22:0] v_lui, v_trap;

    task automatic push(input string nm, input logic [22:0] a, input logic [22:0] b);
        exp_t t;
        t.name = nm;
        t.e1   = a;
        t.e0   = b;
        sb_q.push_back(t);
    endtask

    // One clock cycle: expectation for this cycle, then advance to posedge+1.
    task automatic cyc(input string nm, input logic [22:0] a, input logic [22:0] b);
        push(nm, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                          input logic z, input logic s);
        opcode = op;
        f3     = fn3;
        f7     = fn7;
        zero   = z;
        sign   = s;
    endtask

    // Monitor
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                r = sb_q.pop_front();
                n_cmp++;
                if (act1 !== r.e1) begin
                    n_bad++;
                    $display("FAIL %s (trap dut): got %h expected %h", r.name, act1, r.e1);
                end
                n_cmp++;
                if (act0 !== r.e0) begin
                    n_bad++;
                    $display("FAIL %s (nop dut): got %h expected %h", r.name, act0, r.e0);
                end
            end else if (stim_done) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d entries pending", sb_q.size());
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        v_rst    = ev(4'd0,  0,0,0,0,0,0, 3'd0, 3'd0, 2'd0, 2'd2, 2'd2, 0);
        v_f      = ev(4'd0,  1,1,1,0,0,0, 3'd0, 3'd0, 2'd0, 2'd2, 2'd2, 0);
        v_d_i    = ev(4'd1,  0,0,0,0,0,0, 3'd0, 3'd0, 2'd1, 2'd1, 2'd0, 0);
        v_d_b    = ev(4'd1,  0,0,0,0,0,0, 3'd2, 3'd0, 2'd1, 2'd1, 2'd0, 0);
        v_d_j    = ev(4'd1,  0,0,0,0,0,0, 3'd3, 3'd0, 2'd1, 2'd1, 2'd0, 0);
        v_xr_sub = ev(4'd2,  0,0,0,0,0,0, 3'd0, 3'd1, 2'd2, 2'd0, 2'd0, 0);
        v_xr_ill = ev(4'd2,  0,0,0,0,0,0, 3'd0, 3'd0, 2'd2, 2'd0, 2'd0, 0);
        v_xi_xor = ev(4'd3,  0,0,0,0,0,0, 3'd0, 3'd4, 2'd2, 2'd1, 2'd0, 0);
        v_xi_add = ev(4'd3,  0,0,0,0,0,0, 3'd0, 3'd0, 2'd2, 2'd1, 2'd0, 0);
        v_wb     = ev(4'd4,  0,0,0,0,0,1, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0);
        v_ma_l   = ev(4'd5,  0,0,0,0,0,0, 3'd0, 3'd0, 2'd2, 2'd1, 2'd0, 0);
        v_ma_s   = ev(4'd5,  0,0,0,0,0,0, 3'd1, 3'd0, 2'd2, 2'd1, 2'd0, 0);
        v_mr     = ev(4'd6,  0,0,0,1,0,0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0);
        v_mwb    = ev(4'd7,  0,0,0,0,0,1, 3'd0, 3'd0, 2'd0, 2'd0, 2'd1, 0);
        v_mw     = ev(4'd8,  0,0,0,1,1,0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 0);
        v_br1    = ev(4'd9,  1,0,0,0,0,0, 3'd0, 3'd1, 2'd2, 2'd0, 2'd0, 0);
        v_br0    = ev(4'd9,  0,0,0,0,0,0, 3'd0, 3'd1, 2'd2, 2'd0, 2'd0, 0);
        v_jal    = ev(4'd10, 1,0,0,0,0,0, 3'd0, 3'd0, 2'd1, 2'd2, 2'd0, 0);
        v_jalr   = ev(4'd11, 1,0,0,0,0,0, 3'd0, 3'd0, 2'd1, 2'd2, 2'd0, 0);
        v_lui    = ev(4'd12, 0,0,0,0,0,1, 3'd4, 3'd0, 2'd0, 2'd0, 2'd3, 0);
        v_trap   = ev(4'd13, 0,0,0,0,0,0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0, 1);

        rst = 1'b0;
        set_in(7'b0, 3'b0, 7'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset", v_rst, v_rst);
        rst = 1'b1;

        // sub
        set_in(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
        cyc("sub fetch", v_f, v_f);
        cyc("sub decode", v_d_i, v_d_i);
        cyc("sub exec_r", v_xr_sub, v_xr_sub);
        cyc("sub alu_wb", v_wb, v_wb);

        // xori
        set_in(7'b0010011, 3'b100, 7'b0000000, 1'b0, 1'b0);
        cyc("xori fetch", v_f, v_f);
        cyc("xori decode", v_d_i, v_d_i);
        cyc("xori exec_i", v_xi_xor, v_xi_xor);
        cyc("xori alu_wb", v_wb, v_wb);

        // lw
        set_in(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
        cyc("lw fetch", v_f, v_f);
        cyc("lw decode", v_d_i, v_d_i);
        cyc("lw mem_adr", v_ma_l, v_ma_l);
        cyc("lw mem_read", v_mr, v_mr);
        cyc("lw mem_wb", v_mwb, v_mwb);

        // lui
        set_in(7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("lui fetch", v_f, v_f);
        cyc("lui decode", v_d_i, v_d_i);
        cyc("lui wb", v_lui, v_lui);

        // branches
        set_in(7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0);
        cyc("beq taken fetch", v_f, v_f);
        cyc("beq taken decode", v_d_b, v_d_b);
        cyc("beq taken branch", v_br1, v_br1);
        set_in(7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("beq not-taken fetch", v_f, v_f);
        cyc("beq not-taken decode", v_d_b, v_d_b);
        cyc("beq not-taken branch", v_br0, v_br0);
        set_in(7'b1100011, 3'b101, 7'b0000000, 1'b1, 1'b0);
        cyc("bge taken fetch", v_f, v_f);
        cyc("bge taken decode", v_d_b, v_d_b);
        cyc("bge taken branch", v_br1, v_br1);
        set_in(7'b1100011, 3'b100, 7'b0000000, 1'b0, 1'b0);
        cyc("blt not-taken fetch", v_f, v_f);
        cyc("blt not-taken decode", v_d_b, v_d_b);
        cyc("blt not-taken branch", v_br0, v_br0);

        // jal
        set_in(7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("jal fetch", v_f, v_f);
        cyc("jal decode", v_d_j, v_d_j);
        cyc("jal pc", v_jal, v_jal);
        cyc("jal alu_wb", v_wb, v_wb);

        // jalr
        set_in(7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("jalr fetch", v_f, v_f);
        cyc("jalr decode", v_d_i, v_d_i);
        cyc("jalr exec_i", v_xi_add, v_xi_add);
        cyc("jalr pc", v_jalr, v_jalr);
        cyc("jalr alu_wb", v_wb, v_wb);

        // sw, with reset pulled mid MEM_WRITE
        set_in(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0);
        cyc("sw fetch", v_f, v_f);
        cyc("sw decode", v_d_i, v_d_i);
        cyc("sw mem_adr", v_ma_s, v_ma_s);
        push("sw mem_write", v_mw, v_mw);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset mid-write", v_rst, v_rst);
        rst = 1'b1;
        cyc("fetch after reset", v_f, v_f);
        cyc("sw2 decode", v_d_i, v_d_i);
        cyc("sw2 mem_adr", v_ma_s, v_ma_s);
        cyc("sw2 mem_write", v_mw, v_mw);

        // illegal opcode: trap dut halts, nop dut keeps refetching
        set_in(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0);
        cyc("illegal fetch", v_f, v_f);
        cyc("illegal decode", v_d_i, v_d_i);
        for (int i = 0; i < 10; i++) begin
            cyc("illegal trap hold", v_trap, ((i % 2) == 0) ? v_f : v_d_i);
        end

        rst = 1'b0;
        cyc("reset from trap", v_rst, v_rst);
        rst = 1'b1;

        // and with f7=0100000 is an illegal R-type
        set_in(7'b0110011, 3'b111, 7'b0100000, 1'b0, 1'b0);
        cyc("bad-r fetch", v_f, v_f);
        cyc("bad-r decode", v_d_i, v_d_i);
        cyc("bad-r exec_r", v_xr_ill, v_xr_ill);
        cyc("bad-r after 1", v_trap, v_f);
        cyc("bad-r after 2", v_trap, v_d_i);

        stim_done = 1'b1;
    end

endmodule
